// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline: the canonical NOP word, the
// default reset PC and the instruction-fetch state encoding.
package cpu_pkg;

  // addi x0, x0, 0 -- the bubble injected by IF and by the IF/ID flush.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the PC, keeps at most one instruction-memory
// read outstanding and presents a registered {pc, instr, valid} to IF/ID.
// A redirect from EX retargets the PC immediately and discards any fetch
// that is still in flight for the old path.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pause,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         if_valid_q, if_valid_d;

  logic         consume;
  logic [31:0]  target_pc;

  // The low two bits of the target are architecturally ignored.
  logic         unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc            = {redirect_pc[31:2], 2'b00};

  // IF/ID takes the buffered instruction on every edge it is not paused.
  assign consume = if_valid_q && !pause;

  // Memory request: only issue when the buffer is empty or drains this edge,
  // so a response can never arrive while the buffer is full and held.
  always_comb begin
    imem_req  = (state_q == FETCH_REQ) && (!if_valid_q || !pause);
    imem_addr = pc_q;
  end

  // Next-state logic: FSM, PC, wrong-path drop flag and output buffer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;

    if (consume) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP;
    end

    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (imem_req && imem_gnt) begin
          state_d = FETCH_WAIT;
          // A redirect in the grant cycle makes this fetch wrong-path.
          drop_d  = redirect;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH_REQ;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    // Redirect wins over pause and over any response landing this edge.
    if (redirect) begin
      pc_d       = target_pc;
      if_valid_d = 1'b0;
      if_instr_d = NOP;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a single-outstanding instruction memory model with
// variable grant/latency, directed scenarios for reset, pause, redirect,
// PC wrap and reset during an outstanding read, then a randomized phase.
// The monitor follows the program-order instruction stream: each consumed
// instruction must be the next sequential PC, and a redirect restarts the
// stream at its target.
module tb_if_fetch;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        pause;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  if_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pause       (pause),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory contents: each word holds its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a;
  endfunction

  // Memory model state (single outstanding read).
  bit          outst     = 1'b0;
  int          due       = 0;
  logic [31:0] oaddr     = '0;
  bit          force_en  = 1'b0;
  logic [31:0] force_dat = '0;

  // Scoreboard: redirect targets queued by stimulus, consumed by the monitor.
  logic [31:0] redir_q[$];
  logic [31:0] exp_pc      = RESET_PC_DEFAULT;
  int          n_consumed  = 0;

  // One clock of stimulus: inputs after the edge, grant once imem_req settles,
  // then return at the falling edge for sampling.
  task automatic cycle(input bit rst_v, input bit p, input bit r, input logic [31:0] rpc,
                       input int lat, input bit gnt_en);
    @(posedge clk);
    #1;
    rst_n       = rst_v;
    pause       = p;
    redirect    = r;
    redirect_pc = rpc;
    if (r) redir_q.push_back(rpc);
    if (outst && due == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = force_en ? force_dat : mem_word(oaddr);
      outst       = 1'b0;
      force_en    = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outst) due--;
    end
    #1;
    imem_gnt = gnt_en && imem_req && !outst;
    if (imem_gnt) begin
      outst = 1'b1;
      oaddr = imem_addr;
      due   = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic step(input bit p, input bit r, input logic [31:0] rpc, input int lat, input bit g);
    cycle(1'b1, p, r, rpc, lat, g);
  endtask

  // Monitor: checks every consumed instruction against the program-order stream.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_pc = RESET_PC_DEFAULT;
      redir_q.delete();
    end else begin
      if (!if_valid) check("nop_when_invalid", if_instr, NOP);
      if (if_valid && pause) check("no_req_while_held", {31'd0, imem_req}, 32'd0);
      check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
      if (if_valid && !pause) begin
        check("stream_pc", if_pc, exp_pc);
        check("stream_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (redirect) begin
        if (redir_q.size() == 0) begin
          n_checks++;
          $display("FAIL redirect_queue: got empty expected a queued target at %0t", $time);
        end else begin
          logic [31:0] t;
          t      = redir_q.pop_front();
          exp_pc = {t[31:2], 2'b00};
        end
      end
    end
  end

  task automatic expect_out(input string name, input bit v, input logic [31:0] pc);
    check({name, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    if (v) begin
      check({name, "_pc"}, if_pc, pc);
      check({name, "_instr"}, if_instr, mem_word(pc));
    end else begin
      check({name, "_instr_nop"}, if_instr, NOP);
    end
  endtask

  task automatic expect_req(input string name, input bit req, input logic [31:0] addr);
    check({name, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check({name, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst_n       = 1'b0;
    pause       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Reset state.
    cycle(1'b0, 0, 0, 0, 1, 0);
    cycle(1'b0, 0, 0, 0, 1, 0);
    check("reset_valid", {31'd0, if_valid}, 32'd0);
    check("reset_instr", if_instr, NOP);
    check("reset_pc", if_pc, 32'd0);
    check("reset_req", {31'd0, imem_req}, 32'd0);
    check("reset_addr", imem_addr, RESET_PC_DEFAULT);

    // Zero-wait memory: valid every other cycle, first 3 cycles after release.
    for (int k = 1; k <= 9; k++) begin
      step(0, 0, 0, 1, 1);
      if (k >= 4 && k % 2 == 0) expect_out("zw", 1'b1, 32'((k - 4) * 2));
      else                      expect_out("zw", 1'b0, 32'd0);
      if (k == 1) expect_req("zw_idle", 1'b0, 32'd0);
      if (k == 2) expect_req("zw_first", 1'b1, 32'd0);
    end

    // Pause for 5 cycles with an instruction held.
    for (int k = 10; k <= 14; k++) begin
      step(1, 0, 0, 1, 1);
      expect_out("pause_hold", 1'b1, 32'd12);
      expect_req("pause_hold", 1'b0, 32'd0);
    end
    step(0, 0, 0, 1, 1);
    expect_out("pause_release", 1'b1, 32'd12);
    expect_req("pause_release", 1'b1, 32'd16);
    step(0, 0, 0, 1, 1);
    expect_out("after_release", 1'b0, 32'd0);
    step(0, 0, 0, 1, 0);
    expect_out("next_seq", 1'b1, 32'd16);

    // Redirect during WAIT, stale data arrives two cycles later.
    step(0, 0, 0, 3, 1);
    expect_req("slow_fetch", 1'b1, 32'd20);
    step(0, 1, 32'h0000_0100, 1, 0);
    expect_out("redir_wait", 1'b0, 32'd0);
    step(0, 0, 0, 1, 0);
    expect_out("redir_wait2", 1'b0, 32'd0);
    force_en  = 1'b1;
    force_dat = 32'hDEAD_BEEF;
    step(0, 0, 0, 1, 0);
    expect_out("stale_rvalid", 1'b0, 32'd0);
    step(0, 0, 0, 1, 1);
    expect_out("stale_dropped", 1'b0, 32'd0);
    expect_req("redir_target", 1'b1, 32'h0000_0100);

    // Redirect in the same cycle as rvalid, with pause high.
    step(1, 1, 32'h0000_0200, 1, 1);
    step(0, 0, 0, 1, 1);
    expect_out("redir_rvalid", 1'b0, 32'd0);
    expect_req("redir_rvalid", 1'b1, 32'h0000_0200);
    step(0, 0, 0, 1, 1);

    // Unaligned target near the top of memory, then PC wrap.
    step(0, 1, 32'hFFFF_FFFE, 1, 0);
    expect_out("target_200", 1'b1, 32'h0000_0200);
    step(0, 0, 0, 1, 1);
    expect_out("wrap_redir", 1'b0, 32'd0);
    expect_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 2, 1);
    expect_out("wrap_instr", 1'b1, 32'hFFFF_FFFC);
    expect_req("wrap_zero", 1'b1, 32'h0000_0000);

    // Reset for one cycle while the read is outstanding.
    cycle(1'b0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    expect_out("post_reset", 1'b0, 32'd0);
    expect_req("post_reset_idle", 1'b0, 32'd0);
    step(0, 0, 0, 1, 1);
    expect_out("post_reset_ignored", 1'b0, 32'd0);
    expect_req("post_reset_req", 1'b1, RESET_PC_DEFAULT);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    expect_out("post_reset_first", 1'b1, RESET_PC_DEFAULT);

    // Randomized traffic checked by the stream monitor.
    n_consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, $urandom,
           int'($urandom_range(1, 4)), $urandom_range(0, 9) < 7);
    end
    check("random_progress", {31'd0, n_consumed > 100}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
